// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter: registered round-robin arbiter between the L1 instruction
// and data caches for the shared l1mmu request port. It holds one line request
// until mmu_done or a timeout, then returns the line with a one-cycle done pulse.
module l1_mmu_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int TO_W           = 10
) (
   input  logic         sys_clk,
   input  logic         rst,
   input  logic         i_req_read,
   input  logic [31:0]  i_req_addr,
   output logic         i_done,
   output logic [255:0] i_read_data,
   input  logic         d_req_read,
   input  logic         d_req_write,
   input  logic [31:0]  d_req_addr,
   input  logic [255:0] d_write_data,
   output logic         d_done,
   output logic [255:0] d_read_data,
   output logic         mmu_req_read,
   output logic         mmu_req_write,
   output logic [31:0]  mmu_req_addr,
   output logic [255:0] mmu_write_data,
   input  logic         mmu_done,
   input  logic [255:0] mmu_read_data,
   output logic         timeout_err
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

   state_t         state_q, state_d;
   logic           last_d_q, last_d_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic           mmu_req_read_q, mmu_req_read_d;
   logic           mmu_req_write_q, mmu_req_write_d;
   logic [31:0]    mmu_req_addr_q, mmu_req_addr_d;
   logic [255:0]   mmu_write_data_q, mmu_write_data_d;
   logic           i_done_q, i_done_d;
   logic           d_done_q, d_done_d;
   logic [255:0]   i_rdata_q, i_rdata_d;
   logic [255:0]   d_rdata_q, d_rdata_d;
   logic           timeout_err_q, timeout_err_d;

   logic i_want, d_want, grant_d;

   // Requester view: a D-side tie goes to I unless I was the last one served.
   always_comb begin
      i_want  = i_req_read;
      d_want  = d_req_read | d_req_write;
      grant_d = d_want & (~i_want | ~last_d_q);
   end

   // Next-state and datapath: grant in IDLE, wait for mmu_done or timeout, pulse done.
   always_comb begin
      state_d          = state_q;
      last_d_d         = last_d_q;
      cnt_d            = cnt_q;
      mmu_req_read_d   = mmu_req_read_q;
      mmu_req_write_d  = mmu_req_write_q;
      mmu_req_addr_d   = mmu_req_addr_q;
      mmu_write_data_d = mmu_write_data_q;
      i_done_d         = 1'b0;
      d_done_d         = 1'b0;
      i_rdata_d        = i_rdata_q;
      d_rdata_d        = d_rdata_q;
      timeout_err_d    = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d          = GRANT_D;
               mmu_req_write_d  = d_req_write;
               mmu_req_read_d   = ~d_req_write;  // write wins when both are set
               mmu_req_addr_d   = d_req_addr;
               mmu_write_data_d = d_write_data;
               cnt_d            = '0;
            end else if (i_want) begin
               state_d          = GRANT_I;
               mmu_req_write_d  = 1'b0;
               mmu_req_read_d   = 1'b1;
               mmu_req_addr_d   = i_req_addr;
               mmu_write_data_d = '0;
               cnt_d            = '0;
            end
         end
         GRANT_I, GRANT_D: begin
            if (mmu_done || cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
               state_d         = RESP;
               mmu_req_read_d  = 1'b0;
               mmu_req_write_d = 1'b0;
               mmu_req_addr_d  = '0;
               if (mmu_done) begin
                  last_d_d = (state_q == GRANT_D);
               end else begin
                  timeout_err_d = 1'b1;
               end
               // An aborted request returns an all-zero line.
               if (state_q == GRANT_D) begin
                  d_done_d  = 1'b1;
                  d_rdata_d = mmu_done ? mmu_read_data : '0;
               end else begin
                  i_done_d  = 1'b1;
                  i_rdata_d = mmu_done ? mmu_read_data : '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any outstanding request without a done pulse.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q          <= IDLE;
         last_d_q         <= 1'b1;
         cnt_q            <= '0;
         mmu_req_read_q   <= 1'b0;
         mmu_req_write_q  <= 1'b0;
         mmu_req_addr_q   <= '0;
         mmu_write_data_q <= '0;
         i_done_q         <= 1'b0;
         d_done_q         <= 1'b0;
         i_rdata_q        <= '0;
         d_rdata_q        <= '0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_d_q         <= last_d_d;
         cnt_q            <= cnt_d;
         mmu_req_read_q   <= mmu_req_read_d;
         mmu_req_write_q  <= mmu_req_write_d;
         mmu_req_addr_q   <= mmu_req_addr_d;
         mmu_write_data_q <= mmu_write_data_d;
         i_done_q         <= i_done_d;
         d_done_q         <= d_done_d;
         i_rdata_q        <= i_rdata_d;
         d_rdata_q        <= d_rdata_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   // Outputs come straight from flops.
   always_comb begin
      mmu_req_read   = mmu_req_read_q;
      mmu_req_write  = mmu_req_write_q;
      mmu_req_addr   = mmu_req_addr_q;
      mmu_write_data = mmu_write_data_q;
      i_done         = i_done_q;
      d_done         = d_done_q;
      i_read_data    = i_rdata_q;
      d_read_data    = d_rdata_q;
      timeout_err    = timeout_err_q;
   end

endmodule
